// File: rtl/apb_mgr_bridge_if.sv
// Request/response port plus APB peripheral bus of the APB initiator bridge.
// The master modport is the bridge's view; the slave modport is the requester/completer side.
interface apb_mgr_bridge_if #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
);
    localparam int unsigned StrbWidth = DataWidth / 8;

    logic                 req_valid;
    logic                 req_ready;
    logic [AddrWidth-1:0] req_addr;
    logic                 req_write;
    logic [DataWidth-1:0] req_wdata;
    logic [StrbWidth-1:0] req_strb;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [DataWidth-1:0] rsp_rdata;
    logic                 rsp_err;

    logic [AddrWidth-1:0] paddr;
    logic                 psel;
    logic                 penable;
    logic                 pwrite;
    logic [DataWidth-1:0] pwdata;
    logic [StrbWidth-1:0] pstrb;
    logic [DataWidth-1:0] prdata;
    logic                 pready;
    logic                 pslverr;

    modport master (
        input  req_valid, req_addr, req_write, req_wdata, req_strb, rsp_ready,
        input  prdata, pready, pslverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output paddr, psel, penable, pwrite, pwdata, pstrb
    );

    modport slave (
        output req_valid, req_addr, req_write, req_wdata, req_strb, rsp_ready,
        output prdata, pready, pslverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  paddr, psel, penable, pwrite, pwdata, pstrb
    );
endinterface

// File: rtl/apb_mgr_bridge.sv
// APB initiator: one valid/ready request becomes one APB transfer, one transfer in flight.
// Optional ACCESS-phase timeout abort is enabled by defining APB_MGR_TIMEOUT_EN.
module apb_mgr_bridge #(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    apb_mgr_bridge_if.master    bus,
    output logic                busy,
    output logic                timeout
);
    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e state_q;

    if (TimeoutCycles < 2) begin : g_bad_cfg
        $error("apb_mgr_bridge: TimeoutCycles must be at least 2");
    end

`ifdef APB_MGR_TIMEOUT_EN
    localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);
    localparam logic [CntWidth-1:0] CntLimit = CntWidth'(TimeoutCycles - 1);

    logic [CntWidth-1:0] cnt_q;
    logic                timeout_q;

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    // Reset is active-high here; all outputs are registered so psel/penable drop asynchronously.
    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            state_q       <= StIdle;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            bus.paddr     <= '0;
            bus.psel      <= 1'b0;
            bus.penable   <= 1'b0;
            bus.pwrite    <= 1'b0;
            bus.pwdata    <= '0;
            bus.pstrb     <= '0;
            busy          <= 1'b0;
`ifdef APB_MGR_TIMEOUT_EN
            cnt_q         <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
`ifdef APB_MGR_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        bus.paddr     <= {bus.req_addr[AddrWidth-1:2], 2'b00};
                        bus.pwrite    <= bus.req_write;
                        bus.pwdata    <= bus.req_wdata;
                        bus.pstrb     <= bus.req_write ? bus.req_strb : '0;
                        bus.psel      <= 1'b1;
                        bus.req_ready <= 1'b0;
                        busy          <= 1'b1;
                        state_q       <= StSetup;
                    end
                end
                StSetup: begin
                    bus.penable <= 1'b1;
`ifdef APB_MGR_TIMEOUT_EN
                    cnt_q       <= '0;
`endif
                    state_q     <= StAccess;
                end
                StAccess: begin
                    if (bus.pready) begin
                        bus.rsp_err   <= bus.pslverr;
                        bus.rsp_rdata <= (!bus.pwrite && !bus.pslverr) ? bus.prdata : '0;
                        bus.rsp_valid <= 1'b1;
                        bus.paddr     <= '0;
                        bus.psel      <= 1'b0;
                        bus.penable   <= 1'b0;
                        bus.pwrite    <= 1'b0;
                        bus.pwdata    <= '0;
                        bus.pstrb     <= '0;
                        state_q       <= StResp;
                    end
`ifdef APB_MGR_TIMEOUT_EN
                    else if (cnt_q == CntLimit) begin
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_rdata <= '0;
                        bus.rsp_valid <= 1'b1;
                        bus.paddr     <= '0;
                        bus.psel      <= 1'b0;
                        bus.penable   <= 1'b0;
                        bus.pwrite    <= 1'b0;
                        bus.pwdata    <= '0;
                        bus.pstrb     <= '0;
                        timeout_q     <= 1'b1;
                        state_q       <= StResp;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_rdata <= '0;
                        bus.req_ready <= 1'b1;
                        busy          <= 1'b0;
                        state_q       <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_mgr_bridge.sv
// Directed self-checking bench for apb_mgr_bridge; inputs driven and outputs sampled on negedge.
// The timeout scenario runs only when APB_MGR_TIMEOUT_EN is defined.
module tb_apb_mgr_bridge;
    logic clk_i = 1'b0;
    logic rst_ni = 1'b1;
    logic busy;
    logic timeout;
    int   n_cmp = 0;
    int   n_err = 0;
    int   xfers = 0;
    int   x0;

    always #5 clk_i = ~clk_i;

    apb_mgr_bridge_if #(.AddrWidth(32), .DataWidth(32)) bus ();

    apb_mgr_bridge #(
        .AddrWidth    (32),
        .DataWidth    (32),
        .TimeoutCycles(16)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus),
        .busy   (busy),
        .timeout(timeout)
    );

    // Completed APB transfers seen on the bus.
    always @(posedge clk_i) begin
        if (!rst_ni && bus.psel && bus.penable && bus.pready) xfers <= xfers + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic req(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] s);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_write = w;
        bus.req_wdata = d;
        bus.req_strb  = s;
    endtask

    task automatic rsp_handshake();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("hs_rsp_valid_low", {63'd0, bus.rsp_valid}, 64'd0);
        chk("hs_req_ready", {63'd0, bus.req_ready}, 64'd1);
        chk("hs_busy_low", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        bus.req_valid = 0; bus.req_addr = 0; bus.req_write = 0; bus.req_wdata = 0;
        bus.req_strb = 0; bus.rsp_ready = 0; bus.prdata = 0; bus.pready = 0; bus.pslverr = 0;

        // Reset state
        tick(); tick();
        chk("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
        chk("rst_psel", {63'd0, bus.psel}, 64'd0);
        chk("rst_penable", {63'd0, bus.penable}, 64'd0);
        chk("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_timeout", {63'd0, timeout}, 64'd0);
        chk("rst_paddr", {32'd0, bus.paddr}, 64'd0);
        rst_ni = 1'b0;
        tick();

        // 1: write, pready=1, unaligned address
        req(32'h0000_1006, 1'b1, 32'hA5A5_5A5A, 4'hF);
        bus.pready = 1'b1; bus.prdata = 32'hDEAD_BEEF;
        chk("t1_req_ready_N", {63'd0, bus.req_ready}, 64'd1);
        tick();
        bus.req_valid = 1'b0;
        chk("t1_psel_N1", {63'd0, bus.psel}, 64'd1);
        chk("t1_penable_N1", {63'd0, bus.penable}, 64'd0);
        chk("t1_paddr", {32'd0, bus.paddr}, 64'h1004);
        chk("t1_pwrite", {63'd0, bus.pwrite}, 64'd1);
        chk("t1_pwdata", {32'd0, bus.pwdata}, 64'hA5A5_5A5A);
        chk("t1_pstrb", {60'd0, bus.pstrb}, 64'hF);
        chk("t1_req_ready_busy", {63'd0, bus.req_ready}, 64'd0);
        chk("t1_busy", {63'd0, busy}, 64'd1);
        tick();
        chk("t1_psel_N2", {63'd0, bus.psel}, 64'd1);
        chk("t1_penable_N2", {63'd0, bus.penable}, 64'd1);
        chk("t1_rsp_valid_N2", {63'd0, bus.rsp_valid}, 64'd0);
        tick();
        chk("t1_rsp_valid_N3", {63'd0, bus.rsp_valid}, 64'd1);
        chk("t1_rsp_err", {63'd0, bus.rsp_err}, 64'd0);
        chk("t1_rsp_rdata", {32'd0, bus.rsp_rdata}, 64'd0);
        chk("t1_psel_resp", {63'd0, bus.psel}, 64'd0);
        chk("t1_penable_resp", {63'd0, bus.penable}, 64'd0);
        rsp_handshake();

        // 2: read with three wait states
        req(32'h0000_2000, 1'b0, 32'h0BAD_0BAD, 4'hF);
        bus.pready = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        chk("t2_pstrb_setup", {60'd0, bus.pstrb}, 64'd0);
        chk("t2_pwrite_setup", {63'd0, bus.pwrite}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_psel_acc", {63'd0, bus.psel}, 64'd1);
            chk("t2_penable_acc", {63'd0, bus.penable}, 64'd1);
            chk("t2_paddr_acc", {32'd0, bus.paddr}, 64'h2000);
            chk("t2_pstrb_acc", {60'd0, bus.pstrb}, 64'd0);
            chk("t2_rsp_valid_acc", {63'd0, bus.rsp_valid}, 64'd0);
            bus.pready = (i == 3);
            bus.prdata = (i == 3) ? 32'h1234_5678 : 32'hFFFF_0000;
        end
        tick();
        bus.pready = 1'b0;
        chk("t2_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
        chk("t2_rsp_rdata", {32'd0, bus.rsp_rdata}, 64'h1234_5678);
        chk("t2_rsp_err", {63'd0, bus.rsp_err}, 64'd0);
        rsp_handshake();

        // 3: read with pslverr
        req(32'h0000_3008, 1'b0, 32'h0, 4'h0);
        bus.pready = 1'b1; bus.pslverr = 1'b1; bus.prdata = 32'hFFFF_FFFF;
        tick();
        bus.req_valid = 1'b0;
        tick(); tick();
        chk("t3_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
        chk("t3_rsp_err", {63'd0, bus.rsp_err}, 64'd1);
        chk("t3_rsp_rdata", {32'd0, bus.rsp_rdata}, 64'd0);
        bus.pslverr = 1'b0;
        rsp_handshake();

        // 4: response back-pressure with req_valid held
        x0 = xfers;
        req(32'h0000_0040, 1'b1, 32'h0000_0011, 4'h3);
        tick();
        req(32'h0000_0044, 1'b1, 32'h0000_0022, 4'hC);
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            chk("t4_rsp_held", {63'd0, bus.rsp_valid}, 64'd1);
            chk("t4_req_ready_low", {63'd0, bus.req_ready}, 64'd0);
            chk("t4_psel_idle", {63'd0, bus.psel}, 64'd0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        chk("t4_rsp_still", {63'd0, bus.rsp_valid}, 64'd1);
        tick();
        bus.rsp_ready = 1'b0;
        chk("t4_req_ready_after", {63'd0, bus.req_ready}, 64'd1);
        chk("t4_rsp_dropped", {63'd0, bus.rsp_valid}, 64'd0);
        tick();
        bus.req_valid = 1'b0;
        chk("t4_2nd_psel", {63'd0, bus.psel}, 64'd1);
        chk("t4_2nd_paddr", {32'd0, bus.paddr}, 64'h44);
        chk("t4_2nd_pwdata", {32'd0, bus.pwdata}, 64'h22);
        chk("t4_2nd_pstrb", {60'd0, bus.pstrb}, 64'hC);
        tick(); tick();
        chk("t4_2nd_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
        rsp_handshake();
        chk("t4_xfer_count", 64'(xfers - x0), 64'd2);

        // 5: timeout abort, then completion exactly on the limit cycle
`ifdef APB_MGR_TIMEOUT_EN
        req(32'h0000_5000, 1'b0, 32'h0, 4'h0);
        bus.pready = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("t5_acc_penable", {63'd0, bus.penable}, 64'd1);
            chk("t5_acc_no_to", {63'd0, timeout}, 64'd0);
        end
        tick();
        chk("t5_to_pulse", {63'd0, timeout}, 64'd1);
        chk("t5_to_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
        chk("t5_to_rsp_err", {63'd0, bus.rsp_err}, 64'd1);
        chk("t5_to_rdata", {32'd0, bus.rsp_rdata}, 64'd0);
        chk("t5_to_psel", {63'd0, bus.psel}, 64'd0);
        rsp_handshake();
        chk("t5_to_pulse_end", {63'd0, timeout}, 64'd0);

        req(32'h0000_5004, 1'b0, 32'h0, 4'h0);
        tick();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("t5b_acc_penable", {63'd0, bus.penable}, 64'd1);
            bus.pready = (i == 15);
            bus.prdata = 32'hCAFE_F00D;
        end
        tick();
        bus.pready = 1'b0;
        chk("t5b_no_to", {63'd0, timeout}, 64'd0);
        chk("t5b_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
        chk("t5b_rsp_err", {63'd0, bus.rsp_err}, 64'd0);
        chk("t5b_rsp_rdata", {32'd0, bus.rsp_rdata}, 64'hCAFE_F00D);
        rsp_handshake();
`else
        req(32'h0000_5000, 1'b0, 32'h0, 4'h0);
        bus.pready = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t5n_acc_penable", {63'd0, bus.penable}, 64'd1);
            chk("t5n_no_to", {63'd0, timeout}, 64'd0);
        end
        bus.pready = 1'b1; bus.prdata = 32'h0000_5A5A;
        tick();
        bus.pready = 1'b0;
        chk("t5n_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
        chk("t5n_rsp_rdata", {32'd0, bus.rsp_rdata}, 64'h5A5A);
        rsp_handshake();
`endif

        // 6: asynchronous reset during ACCESS
        req(32'h0000_6000, 1'b0, 32'h0, 4'h0);
        bus.pready = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        tick();
        chk("t6_in_access", {63'd0, bus.penable}, 64'd1);
        #2 rst_ni = 1'b1;
        #1;
        chk("t6_psel_async", {63'd0, bus.psel}, 64'd0);
        chk("t6_penable_async", {63'd0, bus.penable}, 64'd0);
        bus.pready = 1'b1;
        tick();
        chk("t6_no_rsp", {63'd0, bus.rsp_valid}, 64'd0);
        rst_ni = 1'b0;
        tick();
        bus.pready = 1'b0;
        chk("t6_req_ready", {63'd0, bus.req_ready}, 64'd1);
        chk("t6_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        chk("t6_busy", {63'd0, busy}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
